// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start bit, 8 data bits
// LSB first, odd parity, stop bit, then a check of the device acknowledge.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset; releases both lines at once
//   din          byte to send, captured on the accepted w_enable cycle
//   w_enable     one-cycle start strobe, honoured only while tx_idle=1
//   ps2c, ps2d   open-drain PS/2 clock and data (driven 0 or Z)
//   tx_idle      1 while idle; the PS/2 receiver may own the bus
//   tx_done_tick one-cycle pulse at the end of every transfer
//   ack_err      device did not ack; held until the next accepted w_enable
//   tmo_err      device clock timeout; held until the next accepted w_enable

// 2-FF synchronizer followed by a glitch filter. The filtered level only
// follows the input after LEN consecutive samples at the new level.
module ps2_tx_filt #(
    parameter int LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o
);

    localparam int FW = $clog2(LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic [FW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == FW'(LEN - 1)) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign filt_o = filt_q;

endmodule

module ps2_tx #(
    parameter int RTS_CYCLES     = 12000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       w_enable,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err,
    output logic       tmo_err
);

    localparam int CW = $clog2(RTS_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] tmr_q;
    logic [8:0]    sh_q;
    logic [3:0]    n_q;
    logic          oe_c_q;
    logic          oe_d_q;
    logic          idle_q;
    logic          done_q;
    logic          ack_err_q;
    logic          tmo_err_q;
    logic          c_prev_q;

    logic c_filt;
    logic d_filt;
    logic fall_c;
    logic watch;
    logic tmr_hit;

    ps2_tx_filt #(.LEN(FILTER_LEN)) u_filt_c (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (ps2c),
        .filt_o (c_filt)
    );

    ps2_tx_filt #(.LEN(FILTER_LEN)) u_filt_d (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (ps2d),
        .filt_o (d_filt)
    );

    assign fall_c = c_prev_q & ~c_filt;

    // The watchdog only runs while we wait on the device clock.
    assign watch = (state_q == START) || (state_q == DATA) ||
                   (state_q == STOP)  || (state_q == WAIT_IDLE);
    assign tmr_hit = watch && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            sh_q      <= '0;
            n_q       <= '0;
            oe_c_q    <= 1'b0;
            oe_d_q    <= 1'b0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            c_prev_q  <= 1'b1;
        end else begin
            c_prev_q <= c_filt;
            done_q   <= 1'b0;
            // Reload on each device clock edge and outside watched states.
            if (fall_c || !watch) begin
                tmr_q <= '0;
            end else begin
                tmr_q <= tmr_q + 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    oe_c_q <= 1'b0;
                    oe_d_q <= 1'b0;
                    if (w_enable) begin
                        sh_q      <= {~^din, din};
                        ack_err_q <= 1'b0;
                        tmo_err_q <= 1'b0;
                        cnt_q     <= CW'(RTS_CYCLES - 1);
                        oe_c_q    <= 1'b1;
                        idle_q    <= 1'b0;
                        state_q   <= RTS;
                    end
                end
                RTS: begin
                    if (cnt_q == '0) begin
                        // Start bit goes low while the clock is still held.
                        oe_d_q  <= 1'b1;
                        state_q <= START;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                START: begin
                    oe_c_q <= 1'b0;
                    if (fall_c) begin
                        oe_d_q  <= ~sh_q[0];
                        n_q     <= 4'd8;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (fall_c) begin
                        if (n_q == 4'd0) begin
                            oe_d_q  <= 1'b0;
                            state_q <= STOP;
                        end else begin
                            oe_d_q <= ~sh_q[1];
                            sh_q   <= sh_q >> 1;
                            n_q    <= n_q - 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (fall_c) begin
                        ack_err_q <= d_filt;
                        state_q   <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (c_filt && d_filt) begin
                        done_q  <= 1'b1;
                        idle_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (tmr_hit) begin
                tmo_err_q <= 1'b1;
                oe_c_q    <= 1'b0;
                oe_d_q    <= 1'b0;
                done_q    <= 1'b1;
                idle_q    <= 1'b1;
                state_q   <= IDLE;
            end
        end
    end

    assign ps2c = oe_c_q ? 1'b0 : 1'bz;
    assign ps2d = oe_d_q ? 1'b0 : 1'bz;

    assign tx_idle      = idle_q;
    assign tx_done_tick = done_q;
    assign ack_err      = ack_err_q;
    assign tmo_err      = tmo_err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the DUT and a
// scoreboard monitor checks each tx_done_tick against queued expectations.
module tb_ps2_tx;

    localparam int RTS = 60;
    localparam int FLT = 8;
    localparam int TMO = 3000;
    localparam int H   = 50;

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_SILENT = 2;
    localparam int M_GLITCH = 3;
    localparam int M_ABORT  = 4;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ack;
        logic       tmo;
        bit         frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       w_enable = 1'b0;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;
    logic       tmo_err;

    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;

    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    ps2_tx #(
        .RTS_CYCLES     (RTS),
        .FILTER_LEN     (FLT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .w_enable     (w_enable),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .ack_err      (ack_err),
        .tmo_err      (tmo_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   cyc_ctr = 0;
    int   last_done_cyc = 0;
    int   issue_cyc = 0;
    exp_t exp_q[$];

    logic [7:0] dev_byte;
    logic       dev_par;
    logic       dev_stop;
    int         dev_rts;
    bit         dev_ok;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && tx_done_tick === 1'b1) begin
            exp_t e;
            done_cnt++;
            last_done_cyc = cyc_ctr;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_err", ack_err, e.ack);
                chk("tmo_err", tmo_err, e.tmo);
                chk("tx_idle_at_done", tx_idle, 1);
                chk("ps2c_released", ps2c, 1);
                chk("ps2d_released", ps2d, 1);
                if (e.frame) begin
                    chk("dev_frame_seen", dev_ok, 1);
                    chk("dev_byte", dev_byte, e.data);
                    chk("dev_parity", dev_par, e.par);
                    chk("dev_stop", dev_stop, 1);
                    chk("rts_min", 32'(dev_rts >= RTS), 1);
                    chk("rts_max", 32'(dev_rts <= RTS + 2), 1);
                end
            end
        end
    end

    task automatic dev_run(input int mode);
        int n;
        int pulses;
        dev_ok   = 1'b0;
        dev_byte = '0;
        dev_par  = 1'b0;
        dev_stop = 1'b0;
        dev_rts  = 0;
        n = 0;
        while (ps2c !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (ps2c !== 1'b0) begin
            chk("rts_seen", ps2c, 0);
            return;
        end
        while (ps2c === 1'b0 && dev_rts < 1000) begin
            @(negedge clk);
            dev_rts++;
        end
        if (mode == M_SILENT) return;
        repeat (20) @(negedge clk);
        pulses = (mode == M_ABORT) ? 5 : 10;
        for (int i = 0; i < pulses; i++) begin
            dev_c_low = 1'b1;
            repeat (H) @(negedge clk);
            if (i < 8) dev_byte[i] = ps2d;
            else if (i == 8) dev_par = ps2d;
            else dev_stop = ps2d;
            dev_c_low = 1'b0;
            if (mode == M_GLITCH && i == 4) begin
                repeat (10) @(negedge clk);
                dev_c_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_c_low = 1'b0;
                repeat (H - 13) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        if (mode == M_ABORT) return;
        dev_ok = 1'b1;
        dev_d_low = (mode != M_NOACK);
        repeat (20) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (H) @(negedge clk);
        dev_d_low = 1'b0;
    endtask

    task automatic issue(input logic [7:0] b, input exp_t e, input bit push);
        if (push) exp_q.push_back(e);
        @(negedge clk);
        din = b;
        w_enable = 1'b1;
        @(negedge clk);
        w_enable = 1'b0;
        din = ~b;
        issue_cyc = cyc_ctr;
    endtask

    task automatic wait_done(input int start, input int bound);
        int c;
        c = 0;
        while (done_cnt == start && c < bound) begin
            @(posedge clk);
            c++;
        end
        if (done_cnt == start) chk("done_timeout", 0, 1);
        repeat (30) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input logic par,
                         input logic ack, input int mode);
        exp_t e;
        int   s;
        e = '{data: b, par: par, ack: ack, tmo: 1'b0, frame: 1'b1};
        s = done_cnt;
        issue(b, e, 1'b1);
        dev_run(mode);
        wait_done(s, 500);
    endtask

    initial begin
        exp_t e;
        int   s;

        repeat (3) @(negedge clk);
        chk("rst_tx_idle", tx_idle, 1);
        chk("rst_done", tx_done_tick, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_tmo_err", tmo_err, 0);
        chk("rst_ps2c", ps2c, 1);
        chk("rst_ps2d", ps2d, 1);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        frame(8'h41, 1'b1, 1'b0, M_ACK);
        frame(8'h00, 1'b1, 1'b0, M_ACK);
        frame(8'h07, 1'b0, 1'b0, M_ACK);

        frame(8'h5A, 1'b1, 1'b1, M_NOACK);
        repeat (100) @(negedge clk);
        chk("ack_err_hold", ack_err, 1);

        // Second strobe with 0xFF lands mid-DATA and must be ignored.
        e = '{data: 8'h12, par: 1'b1, ack: 1'b0, tmo: 1'b0, frame: 1'b1};
        s = done_cnt;
        issue(8'h12, e, 1'b1);
        chk("ack_err_cleared", ack_err, 0);
        chk("busy_after_accept", tx_idle, 0);
        fork
            dev_run(M_ACK);
            begin
                repeat (RTS + 20 + 300) @(negedge clk);
                din = 8'hFF;
                w_enable = 1'b1;
                @(negedge clk);
                w_enable = 1'b0;
            end
        join
        wait_done(s, 500);

        frame(8'h0B, 1'b0, 1'b0, M_GLITCH);

        e = '{data: 8'h33, par: 1'b1, ack: 1'b0, tmo: 1'b1, frame: 1'b0};
        s = done_cnt;
        issue(8'h33, e, 1'b1);
        dev_run(M_SILENT);
        wait_done(s, TMO + 500);
        chk("tmo_min", 32'(last_done_cyc - issue_cyc >= RTS + TMO - 2), 1);
        chk("tmo_max", 32'(last_done_cyc - issue_cyc <= RTS + TMO + 3), 1);
        chk("tmo_err_hold", tmo_err, 1);

        // Abort mid-DATA with a byte of zeros so ps2d is held low.
        s = done_cnt;
        issue(8'h00, e, 1'b0);
        dev_run(M_ABORT);
        repeat (15) @(negedge clk);
        chk("abort_ps2d_low", ps2d, 0);
        #2 reset = 1'b1;
        #1;
        chk("abort_ps2d_z", ps2d, 1);
        chk("abort_ps2c_z", ps2c, 1);
        chk("abort_tx_idle", tx_idle, 1);
        chk("abort_ack_err", ack_err, 0);
        chk("abort_tmo_err", tmo_err, 0);
        chk("abort_done", tx_done_tick, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        chk("abort_no_tick", done_cnt, s);
        chk("abort_idle_after", tx_idle, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
